// File: rtl/core_pkg.sv
// Shared encodings for the RV32I core: register index width, result_src
// control-word values and forwarding-mux selects.
package core_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_sel.sv
// Per-operand forwarding select: the youngest in-flight writer (MEM) wins over
// WB, and x0 is never forwarded.
module forward_sel
    import core_pkg::*;
#(
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    output logic [1:0]        fwd
);

    logic hit_m;
    logic hit_w;

    assign hit_m = regwrite_m && (rd_m != '0) && (rd_m == rs_e);
    assign hit_w = regwrite_w && (rd_w != '0) && (rd_w == rs_e);

    always_comb begin
        fwd = FWD_REG;
        if (hit_m) begin
            fwd = FWD_MEM;
        end else if (hit_w) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage RV32I pipeline: shadows the control word
// through E/M/W and derives stall, flush and forwarding selects.
module hazard_unit
    import core_pkg::*;
#(
    parameter int REG_AW       = core_pkg::REG_AW,
    parameter int RESULT_SRC_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [REG_AW-1:0]       rs1_d,
    input  logic [REG_AW-1:0]       rs2_d,
    input  logic [REG_AW-1:0]       rd_d,
    input  logic                    regwrite_d,
    input  logic [RESULT_SRC_W-1:0] result_src_d,
    input  logic                    pc_src_e,
    input  logic                    mem_wait,
    output logic                    stall_f,
    output logic                    stall_d,
    output logic                    stall_e,
    output logic                    stall_m,
    output logic                    flush_d,
    output logic                    flush_e,
    output logic                    flush_w,
    output logic [1:0]              forward_a_e,
    output logic [1:0]              forward_b_e
);

    logic [REG_AW-1:0]       rs1_e;
    logic [REG_AW-1:0]       rs2_e;
    logic [REG_AW-1:0]       rd_e;
    logic                    regwrite_e;
    logic [RESULT_SRC_W-1:0] result_src_e;

    logic [REG_AW-1:0]       rd_m;
    logic                    regwrite_m;
    logic [RESULT_SRC_W-1:0] result_src_m;

    logic [REG_AW-1:0]       rd_w;
    logic                    regwrite_w;

    logic lwstall;

    assign lwstall = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0)
                     && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // Priority: mem_wait freezes everything, then a taken branch, then load-use.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lwstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_e        <= '0;
            rs2_e        <= '0;
            rd_e         <= '0;
            regwrite_e   <= 1'b0;
            result_src_e <= '0;
            rd_m         <= '0;
            regwrite_m   <= 1'b0;
            result_src_m <= '0;
            rd_w         <= '0;
            regwrite_w   <= 1'b0;
        end else begin
            if (!stall_e) begin
                if (flush_e) begin
                    rs1_e        <= '0;
                    rs2_e        <= '0;
                    rd_e         <= '0;
                    regwrite_e   <= 1'b0;
                    result_src_e <= '0;
                end else begin
                    rs1_e        <= rs1_d;
                    rs2_e        <= rs2_d;
                    rd_e         <= rd_d;
                    regwrite_e   <= regwrite_d;
                    result_src_e <= result_src_d;
                end
            end
            if (!stall_m) begin
                rd_m         <= rd_e;
                regwrite_m   <= regwrite_e;
                result_src_m <= result_src_e;
            end
            if (flush_w) begin
                rd_w       <= '0;
                regwrite_w <= 1'b0;
            end else begin
                rd_w       <= rd_m;
                regwrite_w <= regwrite_m;
            end
        end
    end

    forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e       (rs1_e),
        .rd_m       (rd_m),
        .regwrite_m (regwrite_m),
        .rd_w       (rd_w),
        .regwrite_w (regwrite_w),
        .fwd        (forward_a_e)
    );

    forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e       (rs2_e),
        .rd_m       (rd_m),
        .regwrite_m (regwrite_m),
        .rd_w       (rd_w),
        .regwrite_w (regwrite_w),
        .fwd        (forward_b_e)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: stimulus queues the expected
// output word per cycle, a negedge monitor pops and compares.
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       regwrite_d;
    logic [1:0] result_src_d;
    logic       pc_src_e, mem_wait;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] forward_a_e, forward_b_e;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .regwrite_d   (regwrite_d),
        .result_src_d (result_src_d),
        .pc_src_e     (pc_src_e),
        .mem_wait     (mem_wait),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fwd_a, fwd_b}
    function automatic logic [10:0] ev(input logic sf, input logic sd, input logic se,
                                       input logic sm, input logic fd, input logic fe,
                                       input logic fw, input logic [1:0] fa,
                                       input logic [1:0] fb);
        return {sf, sd, se, sm, fd, fe, fw, fa, fb};
    endfunction

    localparam logic [10:0] ZERO = 11'b0;

    always @(negedge clk) begin
        logic [10:0] got;
        sb_entry_t   e;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                   forward_a_e, forward_b_e};
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (sf sd se sm fd fe fw fa fb)",
                         e.name, got, e.exp);
            end
        end
    end

    task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                        input logic pc, input logic mw, input logic chk,
                        input logic [10:0] exp, input string nm);
        sb_entry_t e;
        reset        = rst;
        rs1_d        = r1;
        rs2_d        = r2;
        rd_d         = rd;
        regwrite_d   = rw;
        result_src_d = rs;
        pc_src_e     = pc;
        mem_wait     = mw;
        if (chk) begin
            e.exp  = exp;
            e.name = nm;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with garbage decode inputs
        step(1, 7, 7, 7, 1, 2'b01, 0, 0, 0, ZERO, "reset_c1");
        step(1, 7, 7, 7, 1, 2'b01, 0, 0, 1, ZERO, "reset_c2");
        step(0, 7, 7, 0, 0, 2'b00, 0, 0, 1, ZERO, "post_reset_no_stall");

        // back-to-back ALU: add x5 then consumer -> MEM forward
        step(0, 1, 2, 5, 1, 2'b00, 0, 0, 1, ZERO, "add_x5");
        step(0, 5, 3, 6, 1, 2'b00, 0, 0, 1, ZERO, "use_x5_decode");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ev(0,0,0,0,0,0,0,2'b10,2'b00), "fwd_a_mem");
        // producer, unrelated op, consumer -> WB forward
        step(0, 0, 0, 5, 1, 2'b00, 0, 0, 1, ZERO, "add_x5_again");
        step(0, 1, 2, 8, 1, 2'b00, 0, 0, 1, ZERO, "unrelated_x8");
        step(0, 5, 0, 0, 0, 2'b00, 0, 0, 1, ZERO, "use_x5_decode2");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ev(0,0,0,0,0,0,0,2'b01,2'b00), "fwd_a_wb");

        // load-use on rs2
        step(0, 1, 0, 7, 1, 2'b01, 0, 0, 1, ZERO, "lw_x7");
        step(0, 3, 7, 10, 1, 2'b00, 0, 0, 1, ev(1,1,0,0,0,1,0,2'b00,2'b00), "lwstall");
        step(0, 3, 7, 10, 1, 2'b00, 0, 0, 1, ZERO, "lwstall_once_fwd_b_00");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ev(0,0,0,0,0,0,0,2'b00,2'b01), "lw_fwd_b_wb");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ZERO, "nop_a");

        // load into x0: no stall, no forward
        step(0, 1, 0, 0, 1, 2'b01, 0, 0, 1, ZERO, "lw_x0");
        step(0, 0, 0, 11, 1, 2'b00, 0, 0, 1, ZERO, "x0_no_stall");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ZERO, "x0_no_fwd_m");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ZERO, "x0_no_fwd_w");

        // taken branch together with load-use condition
        step(0, 0, 0, 12, 1, 2'b01, 0, 0, 1, ZERO, "lw_x12");
        step(0, 12, 0, 13, 1, 2'b00, 1, 0, 1, ev(0,0,0,0,1,1,0,2'b00,2'b00), "branch_over_lwstall");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ZERO, "after_branch");

        // mem_wait for 3 cycles with MEM forward on A and WB forward on B
        step(0, 0, 0, 3, 1, 2'b00, 0, 0, 1, ZERO, "add_x3");
        step(0, 0, 0, 4, 1, 2'b00, 0, 0, 1, ZERO, "add_x4");
        step(0, 4, 3, 14, 1, 2'b00, 0, 0, 1, ZERO, "use_x4_x3");
        step(0, 1, 2, 15, 1, 2'b00, 0, 1, 1, ev(1,1,1,1,0,0,1,2'b10,2'b01), "mem_wait_c1");
        step(0, 1, 2, 15, 1, 2'b00, 1, 1, 1, ev(1,1,1,1,0,0,1,2'b10,2'b00), "mem_wait_c2_pc_masked");
        step(0, 1, 2, 15, 1, 2'b00, 0, 1, 1, ev(1,1,1,1,0,0,1,2'b10,2'b00), "mem_wait_c3");
        step(0, 1, 2, 15, 1, 2'b00, 0, 0, 1, ev(0,0,0,0,0,0,0,2'b10,2'b00), "mem_wait_release");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ZERO, "advanced");

        // double match: MEM wins on both operands
        step(0, 0, 0, 9, 1, 2'b00, 0, 0, 1, ZERO, "add_x9_a");
        step(0, 0, 0, 9, 1, 2'b00, 0, 0, 1, ZERO, "add_x9_b");
        step(0, 9, 9, 16, 1, 2'b00, 0, 0, 1, ZERO, "use_x9");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, ev(0,0,0,0,0,0,0,2'b10,2'b10), "double_match");

        // reset mid-operation discards an in-flight load-use
        step(0, 0, 0, 7, 1, 2'b01, 0, 0, 1, ZERO, "lw_x7_pre_reset");
        step(1, 7, 7, 0, 0, 2'b00, 0, 0, 0, ZERO, "mid_reset");
        step(0, 7, 7, 0, 0, 2'b00, 0, 0, 1, ZERO, "after_mid_reset");
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, ZERO, "idle");

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumes the decode-stage control word (regwrite, result_src, branch, jump) plus register indices.
- Tracks these through shadow ID/EX, EX/MEM and MEM/WB registers.
- Produces pipeline stall, flush and forwarding-mux selects for the 5-stage RV32I core.
- Sits beside the datapath; it is the single owner of all hazard decisions.

Parameters:
- REG_AW, 5, register index width
- RESULT_SRC_W, 2, width of result_src (00 ALU, 01 load data, 10 PC+4)

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- rs1_d  input  REG_AW  decode-stage source register 1
- rs2_d  input  REG_AW  decode-stage source register 2
- rd_d  input  REG_AW  decode-stage destination register
- regwrite_d  input  1  decode-stage register-write enable
- result_src_d  input  RESULT_SRC_W  decode-stage result select
- pc_src_e  input  1  branch taken or jump resolved in execute
- mem_wait  input  1  data memory not ready; freezes F/D/E/M
- stall_f  output  1  hold PC
- stall_d  output  1  hold IF/ID register
- stall_e  output  1  hold ID/EX register
- stall_m  output  1  hold EX/MEM register
- flush_d  output  1  clear IF/ID register
- flush_e  output  1  clear ID/EX register (insert bubble)
- flush_w  output  1  clear MEM/WB register
- forward_a_e  output  2  ALU src A select: 00 regfile, 01 WB result, 10 MEM ALU result
- forward_b_e  output  2  ALU src B select, same encoding

Behaviour:
- Shadow state:
  - E stage holds rs1_e, rs2_e, rd_e, regwrite_e, result_src_e.
  - M stage holds rd_m, regwrite_m, result_src_m.
  - W stage holds rd_w, regwrite_w.
  - The rs fields are carried only in E.
- Reset: all shadow registers clear to 0 on the cycle reset is sampled high.
  - All outputs are then 0, since all outputs are combinational from shadow state and inputs.
  - Reset mid-operation discards any in-flight hazard; the first cycle after reset is hazard-free.
- Load-use (lwstall):
  - Condition: result_src_e==01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
  - Response: stall_f=stall_d=1, flush_e=1, for exactly one cycle.
  - Next cycle the load is in M, the consumer is in E and forwards 01 from W one cycle later.
- Control hazard:
  - pc_src_e=1 gives flush_d=1 and flush_e=1 in the same cycle.
  - Takes priority over lwstall: when both are set, flush_e=1, stall_f=stall_d=0, flush_d=1.
- mem_wait (highest priority):
  - stall_f=stall_d=stall_e=stall_m=1 and flush_w=1.
  - flush_d, flush_e and lwstall are suppressed (forced 0).
  - E and M shadows hold; W shadow clears (bubble).
  - pc_src_e is re-evaluated once mem_wait drops.
- Shadow update each cycle, unless reset:
  - E: holds if stall_e; clears if flush_e; else loads the decode inputs.
  - M: holds if stall_m; else loads E.
  - W: clears if flush_w; else loads M.
- Forwarding for A (B identical with rs2_e):
  - 10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
  - Else 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e.
  - Else 00.
  - MEM wins over WB when both match.
- x0 is never stalled on or forwarded.
- Latency: all outputs are combinational in the current cycle; shadow state is 1-cycle registered.

Decomposition:
- Shared package core_pkg holds:
  - RESULT_SRC_ALU/LOAD/PC4 constants
  - FWD_REG/FWD_WB/FWD_MEM constants
  - REG_AW
- Use these constants rather than literals in both control-word encoding and hazard logic.
- One natural sub-module: forward_sel, the per-operand priority comparator, instantiated twice for A and B.

Test Plan:
- Reset with garbage inputs: reset=1 for 2 cycles -> every output 0; first cycle after reset with rs1_d=rd of any prior op -> no stall.
- Back-to-back ALU ops:
  - add x5 (rd_d=5, regwrite=1, result_src=00), then rs1_d=5 -> next cycle forward_a_e=10.
  - Unrelated op inserted between them -> forward_a_e=01.
- Load-use:
  - lw x7 then rs2_d=7 -> exactly one cycle with stall_f=stall_d=flush_e=1.
  - Following cycles: forward_b_e=00, then 01 once the load reaches W.
  - Same sequence with rd=0 -> no stall, no forwarding.
- Branch taken during load-use: pc_src_e=1 together with the lwstall condition -> flush_d=flush_e=1, stall_f=stall_d=0.
- mem_wait held 3 cycles with rd_m=4 matching rs1_e:
  - stall_f..stall_m=1 and flush_w=1 each cycle.
  - forward_a_e stays 10 throughout.
  - On release, the pipeline advances and the W bubble has regwrite_w=0.
- Double match: rd_m=rd_w=9, both regwrite, rs1_e=rs2_e=9 -> forward_a_e=forward_b_e=10.
